// File: rtl/json_cmd_rx.sv
// 8N1 UART receiver and byte-level parser for {"T":t,"L":l,"R":r}\n drive commands.
// Build macro JSON_RX_CLAMP_EN: saturate stored L/R magnitudes to CLAMP_MILLI.
module json_cmd_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned MAX_LINE     = 64,
   parameter int unsigned CLAMP_MILLI  = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_in,
   output logic        cmd_valid,
   output logic [7:0]  cmd_t,
   output logic [15:0] cmd_l,
   output logic [15:0] cmd_r,
   output logic        err
);
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned LEN_W = $clog2(MAX_LINE + 1);
   localparam int unsigned MAG_W = 14;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [MAG_W-1:0] CLAMP_M = MAG_W'(CLAMP_MILLI);

`ifdef JSON_RX_CLAMP_EN
   localparam bit CLAMP_ON = 1'b1;
`else
   localparam bit CLAMP_ON = 1'b0;
`endif

   localparam logic [7:0] CH_LBRACE = 8'h7B;
   localparam logic [7:0] CH_RBRACE = 8'h7D;
   localparam logic [7:0] CH_QUOTE  = 8'h22;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_MINUS  = 8'h2D;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_NINE   = 8'h39;
   localparam logic [7:0] CH_T      = 8'h54;
   localparam logic [7:0] CH_L      = 8'h4C;
   localparam logic [7:0] CH_R      = 8'h52;

   localparam logic [1:0] K_T = 2'd0;
   localparam logic [1:0] K_L = 2'd1;
   localparam logic [1:0] K_R = 2'd2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {P_IDLE, P_KQ1, P_KEY, P_KQ2, P_COLON, P_NUM, P_EOL} p_state_e;

   // ---------------- RX stage ----------------
   rx_state_e        rx_state_q, rx_state_d;
   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             byte_vld_q, byte_vld_d;
   logic [7:0]       byte_q, byte_d;
   logic             ferr_q, ferr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         byte_vld_q <= 1'b0;
         byte_q     <= '0;
         ferr_q     <= 1'b0;
      end else begin
         sync1_q    <= uart_in;
         sync2_q    <= sync1_q;
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         byte_vld_q <= byte_vld_d;
         byte_q     <= byte_d;
         ferr_q     <= ferr_d;
      end
   end

   // Start-bit qualification at half bit, then mid-bit sampling of data and stop.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      ferr_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!sync2_q) begin
               rx_state_d = RX_START;
               cnt_d      = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d      = '0;
               bit_d      = '0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shreg_d = {sync2_q, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (cnt_q == FULL_M1) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               if (sync2_q) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shreg_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // ---------------- Parser ----------------
   p_state_e         p_state_q, p_state_d;
   logic [1:0]       key_q, key_d;
   logic             neg_q, neg_d;
   logic             dot_q, dot_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic [1:0]       frac_q, frac_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic [2:0]       seen_q, seen_d;
   logic [7:0]       st_t_q, st_t_d;
   logic [15:0]      st_l_q, st_l_d;
   logic [15:0]      st_r_q, st_r_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             err_q, err_d;
   logic [7:0]       cmd_t_q, cmd_t_d;
   logic [15:0]      cmd_l_q, cmd_l_d;
   logic [15:0]      cmd_r_q, cmd_r_d;

   logic             is_digit, is_term, perr, line_end;
   logic [3:0]       dig;
   logic [MAG_W-1:0] frac_scale, t_acc, mag_sat;
   logic [15:0]      fld_val;

   assign is_digit = (byte_q >= CH_ZERO) && (byte_q <= CH_NINE);
   assign is_term  = (byte_q == CH_COMMA) || (byte_q == CH_RBRACE);
   assign dig      = 4'(byte_q - CH_ZERO);
   assign t_acc    = MAG_W'(10) * mag_q + MAG_W'(dig);
   assign frac_scale = (frac_q == 2'd0) ? MAG_W'(100) :
                       (frac_q == 2'd1) ? MAG_W'(10)  : MAG_W'(1);
   assign mag_sat  = (CLAMP_ON && (mag_q > CLAMP_M)) ? CLAMP_M : mag_q;
   assign fld_val  = neg_q ? (16'd0 - 16'(mag_sat)) : 16'(mag_sat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state_q   <= P_IDLE;
         key_q       <= '0;
         neg_q       <= 1'b0;
         dot_q       <= 1'b0;
         dcnt_q      <= '0;
         frac_q      <= '0;
         mag_q       <= '0;
         seen_q      <= '0;
         st_t_q      <= '0;
         st_l_q      <= '0;
         st_r_q      <= '0;
         len_q       <= '0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         cmd_t_q     <= '0;
         cmd_l_q     <= '0;
         cmd_r_q     <= '0;
      end else begin
         p_state_q   <= p_state_d;
         key_q       <= key_d;
         neg_q       <= neg_d;
         dot_q       <= dot_d;
         dcnt_q      <= dcnt_d;
         frac_q      <= frac_d;
         mag_q       <= mag_d;
         seen_q      <= seen_d;
         st_t_q      <= st_t_d;
         st_l_q      <= st_l_d;
         st_r_q      <= st_r_d;
         len_q       <= len_d;
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         cmd_t_q     <= cmd_t_d;
         cmd_l_q     <= cmd_l_d;
         cmd_r_q     <= cmd_r_d;
      end
   end

   always_comb begin
      p_state_d   = p_state_q;
      key_d       = key_q;
      neg_d       = neg_q;
      dot_d       = dot_q;
      dcnt_d      = dcnt_q;
      frac_d      = frac_q;
      mag_d       = mag_q;
      seen_d      = seen_q;
      st_t_d      = st_t_q;
      st_l_d      = st_l_q;
      st_r_d      = st_r_q;
      len_d       = len_q;
      cmd_t_d     = cmd_t_q;
      cmd_l_d     = cmd_l_q;
      cmd_r_d     = cmd_r_q;
      cmd_valid_d = 1'b0;
      err_d       = 1'b0;
      perr        = 1'b0;
      line_end    = 1'b0;
      if (ferr_q) begin
         err_d     = 1'b1;
         seen_d    = '0;
         p_state_d = P_IDLE;
      end else if (byte_vld_q) begin
         if (p_state_q != P_IDLE) len_d = len_q + LEN_W'(1);
         case (p_state_q)
            P_IDLE: begin
               if (byte_q == CH_LBRACE) begin
                  p_state_d = P_KQ1;
                  seen_d    = '0;
                  len_d     = LEN_W'(1);
               end
            end
            P_KQ1: begin
               if (byte_q == CH_QUOTE) p_state_d = P_KEY;
               else if (byte_q != CH_SPACE) perr = 1'b1;
            end
            P_KEY: begin
               p_state_d = P_KQ2;
               if (byte_q == CH_T) key_d = K_T;
               else if (byte_q == CH_L) key_d = K_L;
               else if (byte_q == CH_R) key_d = K_R;
               else if (byte_q == CH_SPACE) p_state_d = P_KEY;
               else perr = 1'b1;
            end
            P_KQ2: begin
               if (byte_q == CH_QUOTE) p_state_d = P_COLON;
               else if (byte_q != CH_SPACE) perr = 1'b1;
            end
            P_COLON: begin
               if (byte_q == CH_COLON) begin
                  p_state_d = P_NUM;
                  neg_d     = 1'b0;
                  dot_d     = 1'b0;
                  dcnt_d    = '0;
                  frac_d    = '0;
                  mag_d     = '0;
               end else if (byte_q != CH_SPACE) begin
                  perr = 1'b1;
               end
            end
            P_NUM: begin
               // dcnt counts T digits, or the single integer digit of L/R
               if (is_term) begin
                  if (dcnt_q == 2'd0) begin
                     perr = 1'b1;
                  end else begin
                     p_state_d = (byte_q == CH_COMMA) ? P_KQ1 : P_EOL;
                     if (key_q == K_T) begin
                        st_t_d    = mag_q[7:0];
                        seen_d[0] = 1'b1;
                     end else if (key_q == K_L) begin
                        st_l_d    = fld_val;
                        seen_d[1] = 1'b1;
                     end else begin
                        st_r_d    = fld_val;
                        seen_d[2] = 1'b1;
                     end
                  end
               end else if (key_q == K_T) begin
                  if (!is_digit || dcnt_q == 2'd3 || t_acc > MAG_W'(255)) begin
                     perr = 1'b1;
                  end else begin
                     mag_d  = t_acc;
                     dcnt_d = dcnt_q + 2'd1;
                  end
               end else if (byte_q == CH_MINUS) begin
                  if (neg_q || dcnt_q != 2'd0) perr = 1'b1;
                  else neg_d = 1'b1;
               end else if (byte_q == CH_DOT) begin
                  if (dot_q || dcnt_q == 2'd0) perr = 1'b1;
                  else dot_d = 1'b1;
               end else if (is_digit) begin
                  if (!dot_q) begin
                     if (dcnt_q != 2'd0) begin
                        perr = 1'b1;
                     end else begin
                        mag_d  = MAG_W'(dig) * MAG_W'(1000);
                        dcnt_d = 2'd1;
                     end
                  end else if (frac_q == 2'd3) begin
                     perr = 1'b1;
                  end else begin
                     mag_d  = mag_q + MAG_W'(dig) * frac_scale;
                     frac_d = frac_q + 2'd1;
                  end
               end else begin
                  perr = 1'b1;
               end
            end
            P_EOL: begin
               if (byte_q == CH_LF) begin
                  line_end  = 1'b1;
                  p_state_d = P_IDLE;
                  if (seen_q == 3'b111) begin
                     cmd_valid_d = 1'b1;
                     cmd_t_d     = st_t_q;
                     cmd_l_d     = st_l_q;
                     cmd_r_d     = st_r_q;
                  end else begin
                     perr = 1'b1;
                  end
               end else if (byte_q != CH_SPACE && byte_q != CH_CR) begin
                  perr = 1'b1;
               end
            end
            default: p_state_d = P_IDLE;
         endcase
         // A stray '{' is taken as the start of a fresh line
         if (perr) begin
            err_d  = 1'b1;
            seen_d = '0;
            if (byte_q == CH_LBRACE) begin
               p_state_d = P_KQ1;
               len_d     = LEN_W'(1);
            end else begin
               p_state_d = P_IDLE;
            end
         end else if (p_state_q != P_IDLE && !line_end && len_d == LEN_W'(MAX_LINE)) begin
            err_d     = 1'b1;
            seen_d    = '0;
            p_state_d = P_IDLE;
         end
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign err       = err_q;
   assign cmd_t     = cmd_t_q;
   assign cmd_l     = cmd_l_q;
   assign cmd_r     = cmd_r_q;

endmodule

// File: tb/tb_json_cmd_rx.sv
// Directed bench for json_cmd_rx: UART-level line stimulus with hand-computed results.
module tb_json_cmd_rx;
   localparam int unsigned BIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_in = 1'b1;
   logic        cmd_valid;
   logic [7:0]  cmd_t;
   logic [15:0] cmd_l;
   logic [15:0] cmd_r;
   logic        err;

   int checks = 0;
   int fails = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   json_cmd_rx #(.CLKS_PER_BIT(BIT), .MAX_LINE(64), .CLAMP_MILLI(500)) dut (
      .clk(clk), .rst(rst), .uart_in(uart_in), .cmd_valid(cmd_valid),
      .cmd_t(cmd_t), .cmd_l(cmd_l), .cmd_r(cmd_r), .err(err)
   );

   always #5 clk = ~clk;

   // Strobe counters; a pulse held for two cycles counts twice
   always @(negedge clk) begin
      if (cmd_valid) valid_cnt++;
      if (err) err_cnt++;
      if (cmd_valid && err) both_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_in = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_in = b[i];
         repeat (BIT) @(posedge clk);
      end
      uart_in = stop_bit;
      repeat (BIT) @(posedge clk);
      uart_in = 1'b1;
      repeat (BIT) @(posedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
      repeat (4 * BIT) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      uart_in = 1'b1;
      repeat (n * BIT) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      rst = 1'b0;
      idle_bits(2);
      checks += 5;
      if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", cmd_valid); end
      if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err); end
      if (cmd_t !== 8'd0) begin fails++; $display("FAIL reset_t got %0d want 0", cmd_t); end
      if (cmd_l !== 16'd0) begin fails++; $display("FAIL reset_l got %h want 0000", cmd_l); end
      if (cmd_r !== 16'd0) begin fails++; $display("FAIL reset_r got %h want 0000", cmd_r); end
   endtask

   task automatic test_basic;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{\"T\":1,\"L\":-0.15,\"R\":0.15}\n");
      checks += 5;
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL basic_valid got %0d want 1", valid_cnt - v0); end
      if (err_cnt - e0 !== 0) begin fails++; $display("FAIL basic_err got %0d want 0", err_cnt - e0); end
      if (cmd_t !== 8'd1) begin fails++; $display("FAIL basic_t got %0d want 1", cmd_t); end
      if (cmd_l !== 16'hFF6A) begin fails++; $display("FAIL basic_l got %h want ff6a", cmd_l); end
      if (cmd_r !== 16'd150) begin fails++; $display("FAIL basic_r got %0d want 150", cmd_r); end
   endtask

   task automatic test_fractions;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{\"T\":1,\"L\":0.05,\"R\":0.5}\n");
      checks += 3;
      if (cmd_t !== 8'd1) begin fails++; $display("FAIL frac_t got %0d want 1", cmd_t); end
      if (cmd_l !== 16'd50) begin fails++; $display("FAIL frac_l got %0d want 50", cmd_l); end
      if (cmd_r !== 16'd500) begin fails++; $display("FAIL frac_r got %0d want 500", cmd_r); end
      send_str("{\"T\":1,\"L\":0,\"R\":0}\n");
      checks += 4;
      if (cmd_l !== 16'd0) begin fails++; $display("FAIL zero_l got %0d want 0", cmd_l); end
      if (cmd_r !== 16'd0) begin fails++; $display("FAIL zero_r got %0d want 0", cmd_r); end
      if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL frac_valid got %0d want 2", valid_cnt - v0); end
      if (err_cnt - e0 !== 0) begin fails++; $display("FAIL frac_err got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_bad_key;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{\"T\":1,\"X\":0}\n");
      checks += 5;
      if (err_cnt - e0 !== 1) begin fails++; $display("FAIL badkey_err got %0d want 1", err_cnt - e0); end
      if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL badkey_valid got %0d want 0", valid_cnt - v0); end
      if (cmd_t !== 8'd1) begin fails++; $display("FAIL badkey_t got %0d want 1", cmd_t); end
      if (cmd_l !== 16'd0) begin fails++; $display("FAIL badkey_l got %0d want 0", cmd_l); end
      if (cmd_r !== 16'd0) begin fails++; $display("FAIL badkey_r got %0d want 0", cmd_r); end
   endtask

   task automatic test_framing;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{\"T\":7,\"L\":");
      send_byte(8'h35, 1'b0);
      idle_bits(12);
      send_str(",\"R\":2}\n");
      checks += 2;
      if (err_cnt - e0 !== 1) begin fails++; $display("FAIL frame_err got %0d want 1", err_cnt - e0); end
      if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL frame_valid got %0d want 0", valid_cnt - v0); end
      send_str("{\"T\":2,\"L\":0.5,\"R\":-0.25}\n");
      checks += 4;
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL frame_next_valid got %0d want 1", valid_cnt - v0); end
      if (cmd_t !== 8'd2) begin fails++; $display("FAIL frame_next_t got %0d want 2", cmd_t); end
      if (cmd_l !== 16'd500) begin fails++; $display("FAIL frame_next_l got %0d want 500", cmd_l); end
      if (cmd_r !== 16'hFF06) begin fails++; $display("FAIL frame_next_r got %h want ff06", cmd_r); end
   endtask

   task automatic test_clamp;
`ifdef JSON_RX_CLAMP_EN
      logic [15:0] exp_l = 16'd500;
      logic [15:0] exp_r = 16'hFE0C;
`else
      logic [15:0] exp_l = 16'd900;
      logic [15:0] exp_r = 16'hFC7C;
`endif
      int e0 = err_cnt;
      send_str("{\"T\":3,\"L\":0.9,\"R\":-0.9}\n");
      checks += 3;
      if (cmd_l !== exp_l) begin fails++; $display("FAIL clamp_l got %h want %h", cmd_l, exp_l); end
      if (cmd_r !== exp_r) begin fails++; $display("FAIL clamp_r got %h want %h", cmd_r, exp_r); end
      if (err_cnt - e0 !== 0) begin fails++; $display("FAIL clamp_err got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_boundaries;
      string bad [5] = '{
         "{\"T\":256,\"L\":0,\"R\":0}\n",
         "{\"T\":1,\"L\":12,\"R\":0}\n",
         "{\"T\":1,\"L\":0.1234,\"R\":0}\n",
         "{\"T\":1,\"L\":0}\n",
         "{\"T\":1,\"L\":-,\"R\":0}\n"
      };
      int v0 = valid_cnt;
      send_str("{\"T\":255,\"L\":0.001,\"R\":-0.0}\n");
      checks += 4;
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL t255_valid got %0d want 1", valid_cnt - v0); end
      if (cmd_t !== 8'd255) begin fails++; $display("FAIL t255_t got %0d want 255", cmd_t); end
      if (cmd_l !== 16'd1) begin fails++; $display("FAIL t255_l got %0d want 1", cmd_l); end
      if (cmd_r !== 16'd0) begin fails++; $display("FAIL t255_r got %0d want 0", cmd_r); end
      for (int i = 0; i < 5; i++) begin
         int vb = valid_cnt, eb = err_cnt;
         send_str(bad[i]);
         checks += 2;
         if (err_cnt - eb !== 1) begin fails++; $display("FAIL bad_line%0d_err got %0d want 1", i, err_cnt - eb); end
         if (valid_cnt - vb !== 0) begin fails++; $display("FAIL bad_line%0d_valid got %0d want 0", i, valid_cnt - vb); end
      end
      checks += 1;
      if (cmd_t !== 8'd255) begin fails++; $display("FAIL bad_hold_t got %0d want 255", cmd_t); end
   endtask

   task automatic test_whitespace;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{ \"T\":4, \"L\":0.2,\"R\":0.3} \r\n");
      checks += 5;
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL ws_valid got %0d want 1", valid_cnt - v0); end
      if (err_cnt - e0 !== 0) begin fails++; $display("FAIL ws_err got %0d want 0", err_cnt - e0); end
      if (cmd_t !== 8'd4) begin fails++; $display("FAIL ws_t got %0d want 4", cmd_t); end
      if (cmd_l !== 16'd200) begin fails++; $display("FAIL ws_l got %0d want 200", cmd_l); end
      if (cmd_r !== 16'd300) begin fails++; $display("FAIL ws_r got %0d want 300", cmd_r); end
   endtask

   task automatic test_restart;
      int v0 = valid_cnt, e0 = err_cnt;
      send_str("{\"T\":{\"T\":6,\"L\":0,\"R\":0}\n");
      checks += 3;
      if (err_cnt - e0 !== 1) begin fails++; $display("FAIL restart_err got %0d want 1", err_cnt - e0); end
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL restart_valid got %0d want 1", valid_cnt - v0); end
      if (cmd_t !== 8'd6) begin fails++; $display("FAIL restart_t got %0d want 6", cmd_t); end
   endtask

   task automatic test_line_length;
      int v0 = valid_cnt, e0 = err_cnt;
      string s = "{";
      for (int i = 0; i < 10; i++) s = {s, "\"T\":1,"};
      s = {s, "\"L\":0,\"R\":0}\n"};
      send_str(s);
      checks += 3;
      if (err_cnt - e0 !== 1) begin fails++; $display("FAIL long_err got %0d want 1", err_cnt - e0); end
      if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL long_valid got %0d want 0", valid_cnt - v0); end
      if (cmd_t !== 8'd6) begin fails++; $display("FAIL long_t got %0d want 6", cmd_t); end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      string s = "{\"T\":5,\"L\":1,\"R\":1}\n";
      for (int i = 0; i < 9; i++) send_byte(s[i], 1'b1);
      uart_in = 1'b0;
      repeat (3 * BIT) @(posedge clk);
      rst = 1'b1;
      uart_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (cmd_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", cmd_valid); end
      if (err !== 1'b0) begin fails++; $display("FAIL midrst_errsig got %0b want 0", err); end
      if (cmd_t !== 8'd0) begin fails++; $display("FAIL midrst_t got %0d want 0", cmd_t); end
      if (cmd_l !== 16'd0) begin fails++; $display("FAIL midrst_l got %0d want 0", cmd_l); end
      if (cmd_r !== 16'd0) begin fails++; $display("FAIL midrst_r got %0d want 0", cmd_r); end
      v0 = valid_cnt;
      e0 = err_cnt;
      rst = 1'b0;
      idle_bits(12);
      checks += 2;
      if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL midrst_nostrobe_v got %0d want 0", valid_cnt - v0); end
      if (err_cnt - e0 !== 0) begin fails++; $display("FAIL midrst_nostrobe_e got %0d want 0", err_cnt - e0); end
      send_str("{\"T\":9,\"L\":-0.125,\"R\":0.375}\n");
      checks += 4;
      if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL midrst_next_valid got %0d want 1", valid_cnt - v0); end
      if (cmd_t !== 8'd9) begin fails++; $display("FAIL midrst_next_t got %0d want 9", cmd_t); end
      if (cmd_l !== 16'hFF83) begin fails++; $display("FAIL midrst_next_l got %h want ff83", cmd_l); end
      if (cmd_r !== 16'd375) begin fails++; $display("FAIL midrst_next_r got %0d want 375", cmd_r); end
   endtask

   task automatic test_exclusive;
      checks += 1;
      if (both_cnt !== 0) begin fails++; $display("FAIL valid_err_overlap got %0d want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fractions();
      test_bad_key();
      test_framing();
      test_clamp();
      test_boundaries();
      test_whitespace();
      test_restart();
      test_line_length();
      test_reset_mid();
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
